// File: rtl/fft8_sequencer.sv
// fft8_sequencer: handshake, stage select, twiddle and output framing control for an
// 8-point radix-2 SDF FFT pipeline. Define FFT_SEQ_BITREV_EN for bit-reversed out_idx.
module fft8_sequencer #(
  parameter int N   = 8,
  parameter int LAT = 8,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [N-1:0]  in_data,
  output logic          in_ready,
  output logic [N-1:0]  pipe_data,
  output logic          pipe_en,
  output logic [2:0]    sel,
  output logic [N-1:0]  tw1,
  output logic [N-1:0]  tw2,
  output logic          out_valid,
  output logic [2:0]    out_idx,
  output logic          out_sof,
  output logic          out_eof,
  output logic          busy,
  output logic [CW-1:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [N-1:0] TW_ONE  = N'(64);
  localparam logic [N-1:0] TW_R2   = N'(45);
  localparam logic [N-1:0] TW_NR2  = N'(-45);

  state_t              state_q, state_d;
  logic [2:0]          sel_q, sel_d;
  logic [LAT-1:0]      tag_vld_q, tag_vld_d;
  logic [LAT-1:0][2:0] tag_sel_q, tag_sel_d;
  logic [CW-1:0]       frame_cnt_q, frame_cnt_d;

  logic       accept, boundary, flush_cyc;
  logic       in_flight, more_in_flight;
  logic [2:0] tag_out;

  always_comb begin
    in_flight      = |tag_vld_q;
    more_in_flight = |tag_vld_q[LAT-2:0];

    in_ready  = (state_q != FLUSH);
    accept    = in_valid & in_ready;
    boundary  = (state_q == RUN) & ~in_valid & (sel_q == 3'd0);
    // The frame-boundary cycle already pushes the first flush zero so output bins stay contiguous.
    flush_cyc = (state_q == FLUSH) | (boundary & in_flight);
    pipe_en   = accept | flush_cyc;
    pipe_data = flush_cyc ? '0 : in_data;

    tag_out   = tag_sel_q[LAT-1];
    out_valid = pipe_en & tag_vld_q[LAT-1];
    out_sof   = out_valid & (tag_out == 3'd0);
    out_eof   = out_valid & (tag_out == 3'd7);
`ifdef FFT_SEQ_BITREV_EN
    out_idx   = out_valid ? {tag_out[0], tag_out[1], tag_out[2]} : '0;
`else
    out_idx   = out_valid ? tag_out : '0;
`endif

    sel_d     = pipe_en ? sel_q + 3'd1 : sel_q;
    tag_vld_d = tag_vld_q;
    tag_sel_d = tag_sel_q;
    if (pipe_en) begin
      tag_vld_d = {tag_vld_q[LAT-2:0], accept};
      tag_sel_d = {tag_sel_q[LAT-2:0], sel_q};
    end
    frame_cnt_d = frame_cnt_q + CW'(out_eof);

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (boundary) state_d = more_in_flight ? FLUSH : IDLE;
      FLUSH:   if (!more_in_flight) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    unique case (sel_q[1:0])
      2'd0:    tw1 = TW_ONE;
      2'd1:    tw1 = TW_R2;
      2'd2:    tw1 = '0;
      default: tw1 = TW_NR2;
    endcase
    tw2 = sel_q[0] ? '0 : TW_ONE;
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      tag_vld_q   <= '0;
      tag_sel_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      tag_vld_q   <= tag_vld_d;
      tag_sel_q   <= tag_sel_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);
  assign frame_cnt = frame_cnt_q;

endmodule
